// File: rtl/token_dispatcher.sv
//==============================================================================
// Module      : token_dispatcher
// Description : Splits snappy literal/copy tokens into sub-parser commands and
//               owns the running output write address.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module token_dispatcher #(
  parameter int PARSER_NUM = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tok_valid,
  output logic         tok_ready,
  input  logic         tok_is_copy,
  input  logic [15:0]  tok_length,
  input  logic [15:0]  tok_offset,
  input  logic         lit_dvalid,
  output logic         lit_dready,
  input  logic [127:0] lit_din,
  input  logic         stall,
  output logic [127:0] lit_data,
  output logic [3:0]   lit_length,
  output logic [15:0]  lit_address,
  output logic         lit_valid,
  output logic [5:0]   copy_length,
  output logic [15:0]  copy_address,
  output logic [15:0]  copy_offset,
  output logic         copy_valid,
  output logic [15:0]  wr_ptr,
  output logic         error
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LIT  = 2'd1,
    S_COPY = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [16:0] r_rem;
  logic [15:0] r_offset;
  logic [15:0] r_wr_ptr;

  logic        w_tok_acc;
  logic        w_beat_acc;
  logic        w_copy_go;
  logic        w_bad_copy;
  logic [16:0] w_lit_n;
  logic [16:0] w_copy_n;
  logic [16:0] w_issue_n;

  // Instance index is informational only.
  if (PARSER_NUM < 0) begin : g_parser_num_unused
  end

  assign w_bad_copy = tok_is_copy && (tok_offset == 16'd0);
  assign wr_ptr     = r_wr_ptr;

  always_comb begin
    w_next     = r_state;
    tok_ready  = 1'b0;
    lit_dready = 1'b0;
    w_tok_acc  = 1'b0;
    w_beat_acc = 1'b0;
    w_copy_go  = 1'b0;
    w_issue_n  = 17'd0;
    w_lit_n    = (r_rem > 17'd16) ? 17'd16 : r_rem;
    w_copy_n   = (r_rem > 17'd64) ? 17'd64 : r_rem;
    // Capping at the offset keeps a chunk from reading bytes it writes itself.
    if ({1'b0, r_offset} < w_copy_n) begin
      w_copy_n = {1'b0, r_offset};
    end
    case (r_state)
      S_IDLE: begin
        tok_ready = ~stall;
        w_tok_acc = tok_valid & ~stall;
        if (w_tok_acc && !w_bad_copy) begin
          w_next = tok_is_copy ? S_COPY : S_LIT;
        end
      end
      S_LIT: begin
        lit_dready = ~stall;
        w_beat_acc = lit_dvalid & ~stall;
        w_issue_n  = w_lit_n;
        if (w_beat_acc && (r_rem == w_lit_n)) begin
          w_next = S_IDLE;
        end
      end
      S_COPY: begin
        w_copy_go = ~stall;
        w_issue_n = w_copy_n;
        if (w_copy_go && (r_rem == w_copy_n)) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem        <= 17'd0;
      r_offset     <= 16'd0;
      r_wr_ptr     <= 16'd0;
      error        <= 1'b0;
      lit_valid    <= 1'b0;
      lit_data     <= 128'd0;
      lit_length   <= 4'd0;
      lit_address  <= 16'd0;
      copy_valid   <= 1'b0;
      copy_length  <= 6'd0;
      copy_address <= 16'd0;
      copy_offset  <= 16'd0;
    end else begin
      lit_valid  <= 1'b0;
      copy_valid <= 1'b0;
      if (w_tok_acc) begin
        if (w_bad_copy) begin
          error <= 1'b1;
        end else begin
          r_rem    <= {1'b0, tok_length} + 17'd1;
          r_offset <= tok_offset;
        end
      end
      if (w_beat_acc) begin
        lit_valid   <= 1'b1;
        lit_data    <= lit_din;
        lit_length  <= w_lit_n[3:0] - 4'd1;
        lit_address <= r_wr_ptr;
      end
      if (w_copy_go) begin
        copy_valid   <= 1'b1;
        copy_length  <= w_copy_n[5:0] - 6'd1;
        copy_address <= r_wr_ptr;
        copy_offset  <= r_offset;
      end
      if (w_beat_acc || w_copy_go) begin
        r_wr_ptr <= r_wr_ptr + w_issue_n[15:0];
        r_rem    <= r_rem - w_issue_n;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_token_dispatcher.sv
//==============================================================================
// Module      : tb_token_dispatcher
// Description : Randomized scoreboard bench for token_dispatcher.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_token_dispatcher;

  logic         clk = 1'b0;
  logic         rst;
  logic         tok_valid;
  logic         tok_ready;
  logic         tok_is_copy;
  logic [15:0]  tok_length;
  logic [15:0]  tok_offset;
  logic         lit_dvalid;
  logic         lit_dready;
  logic [127:0] lit_din;
  logic         stall;
  logic [127:0] lit_data;
  logic [3:0]   lit_length;
  logic [15:0]  lit_address;
  logic         lit_valid;
  logic [5:0]   copy_length;
  logic [15:0]  copy_address;
  logic [15:0]  copy_offset;
  logic         copy_valid;
  logic [15:0]  wr_ptr;
  logic         error;

  always #5 clk = ~clk;

  token_dispatcher #(.PARSER_NUM(0)) dut (
    .clk(clk), .rst(rst),
    .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_is_copy(tok_is_copy),
    .tok_length(tok_length), .tok_offset(tok_offset),
    .lit_dvalid(lit_dvalid), .lit_dready(lit_dready), .lit_din(lit_din),
    .stall(stall),
    .lit_data(lit_data), .lit_length(lit_length), .lit_address(lit_address),
    .lit_valid(lit_valid),
    .copy_length(copy_length), .copy_address(copy_address),
    .copy_offset(copy_offset), .copy_valid(copy_valid),
    .wr_ptr(wr_ptr), .error(error)
  );

  typedef struct {
    bit           is_copy;
    int           len;
    logic [15:0]  addr;
    logic [15:0]  off;
    logic [127:0] data;
  } cmd_t;

  cmd_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: 0 idle, 1 literal in progress, 2 copy in progress.
  int          m_mode = 0;
  int          m_rem  = 0;
  int          m_off  = 0;
  logic [15:0] m_wr   = 16'd0;
  logic        m_err  = 1'b0;

  bit p_valid = 0;
  bit p_copy  = 0;
  int p_len   = 1;
  int p_off   = 1;
  int stall_pct   = 0;
  int force_stall = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  initial begin : monitor
    cmd_t e;
    forever begin
      @(negedge clk);
      if (lit_valid && copy_valid) chk("both_valid", 1'b1, 1'b0);
      if (lit_valid || copy_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_cmd", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk("cmd_type", copy_valid, e.is_copy);
          if (e.is_copy) begin
            chk("copy_length", copy_length, 128'(e.len - 1));
            chk("copy_address", copy_address, e.addr);
            chk("copy_offset", copy_offset, e.off);
          end else begin
            chk("lit_length", lit_length, 128'(e.len - 1));
            chk("lit_address", lit_address, e.addr);
            chk("lit_data", lit_data, e.data);
          end
        end
      end
    end
  end

  task automatic cycle();
    cmd_t c;
    int   n;
    @(negedge clk);
    if (force_stall > 0) begin
      stall = 1'b1;
      force_stall--;
    end else begin
      stall = ($urandom_range(99) < stall_pct);
    end
    tok_valid   = p_valid;
    tok_is_copy = p_copy;
    tok_length  = 16'(p_len - 1);
    tok_offset  = 16'(p_off);
    lit_dvalid  = ($urandom_range(99) < 80);
    lit_din     = {$urandom(), $urandom(), $urandom(), $urandom()};
    #1;
    chk("tok_ready", tok_ready, (m_mode == 0) && !stall);
    chk("lit_dready", lit_dready, (m_mode == 1) && !stall);
    chk("wr_ptr", wr_ptr, m_wr);
    chk("error", error, m_err);
    if (stall) return;
    if (m_mode == 0) begin
      if (p_valid) begin
        p_valid = 0;
        if (p_copy && p_off == 0) begin
          m_err = 1'b1;
        end else begin
          m_rem  = p_len;
          m_off  = p_off;
          m_mode = p_copy ? 2 : 1;
        end
      end
    end else if (m_mode == 1 && lit_dvalid) begin
      n = (m_rem < 16) ? m_rem : 16;
      c.is_copy = 0; c.len = n; c.addr = m_wr; c.off = 16'd0; c.data = lit_din;
      exp_q.push_back(c);
      m_wr  = m_wr + 16'(n);
      m_rem = m_rem - n;
      if (m_rem == 0) m_mode = 0;
    end else if (m_mode == 2) begin
      n = (m_rem < 64) ? m_rem : 64;
      if (m_off < n) n = m_off;
      c.is_copy = 1; c.len = n; c.addr = m_wr; c.off = 16'(m_off); c.data = '0;
      exp_q.push_back(c);
      m_wr  = m_wr + 16'(n);
      m_rem = m_rem - n;
      if (m_rem == 0) m_mode = 0;
    end
  endtask

  task automatic run_token(input bit is_copy, input int len, input int off);
    int guard;
    p_copy = is_copy; p_len = len; p_off = off; p_valid = 1;
    guard = 0;
    while ((p_valid || m_mode != 0) && guard < 20000) begin
      cycle();
      guard++;
    end
    if (guard >= 20000) chk("token_timeout", 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; tok_valid = 1'b0; lit_dvalid = 1'b0; stall = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_lit_valid", lit_valid, 1'b0);
    chk("rst_copy_valid", copy_valid, 1'b0);
    chk("rst_wr_ptr", wr_ptr, 16'd0);
    chk("rst_error", error, 1'b0);
    chk("rst_queue_empty", 128'(exp_q.size()), 128'd0);
    exp_q.delete();
    m_mode = 0; m_wr = 16'd0; m_err = 1'b0; p_valid = 0;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; tok_valid = 1'b0; tok_is_copy = 1'b0; tok_length = 16'd0;
    tok_offset = 16'd0; lit_dvalid = 1'b0; lit_din = '0; stall = 1'b0;
    repeat (2) @(posedge clk);
    do_reset();

    run_token(0, 5, 0);
    cycle();
    chk("t1_wr_ptr", wr_ptr, 16'd5);
    run_token(0, 40, 0);
    cycle();
    chk("t2_wr_ptr", wr_ptr, 16'd45);
    run_token(0, 55, 0);
    run_token(1, 64, 4);
    cycle();
    chk("t3_wr_ptr", wr_ptr, 16'd164);
    run_token(1, 100, 200);
    force_stall = 3;
    run_token(0, 64, 0);

    stall_pct = 20;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(1) == 0)
        run_token(0, 1 + $urandom_range(($urandom_range(9) == 0) ? 600 : 60), 0);
      else
        run_token(1, 1 + $urandom_range(($urandom_range(9) == 0) ? 1500 : 150),
                  ($urandom_range(19) == 0) ? 0 : 1 + $urandom_range(($urandom_range(1) == 0) ? 8 : 300));
    end

    stall_pct = 0;
    do_reset();
    run_token(0, 16'hFFF8, 0);
    run_token(0, 16, 0);
    cycle();
    chk("wrap_wr_ptr", wr_ptr, 16'h0008);
    run_token(1, 10, 0);
    cycle();
    chk("err_sticky", error, 1'b1);
    stall_pct = 15;
    run_token(1, 65536, 64);

    p_copy = 1; p_len = 3000; p_off = 100; p_valid = 1;
    repeat (6) cycle();
    do_reset();
    repeat (3) cycle();
    chk("end_queue_empty", 128'(exp_q.size()), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
